q_operand_entry: RTL and testbench
==================================

Name: q_operand_entry

Overview:
- Upstream operand-entry stage for the quaternary ALU. It collects base-4 digits and an opcode from a keypad/host strobe interface.
- Packs each 2-digit operand into the decimal-packed 7-bit form the ALU consumes: tens digit ×10 + ones digit, each digit 0..3, so legal values are 0..33.
- Presents A, B and ALU_Sel as one registered transaction with a valid/ack handshake.

Parameters:
- BASE, 4, digit radix; digit values ≥ BASE are rejected.
- MAX_OP, 4, highest legal opcode (0000 add, 0001 sub, 0010 shl, 0011 shr, 0100 gt).
- OUT_W, 7, width of packed operand outputs.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort; returns the block to start of entry.
- digit_in  in  4  entered digit.
- digit_valid  in  1  one-cycle strobe qualifying digit_in.
- op_in  in  4  entered opcode.
- op_valid  in  1  one-cycle strobe qualifying op_in.
- busy  out  1  high in ISSUE; entry strobes are ignored while high.
- err  out  1  one-cycle pulse on any rejected strobe.
- A  out  OUT_W  packed operand A.
- B  out  OUT_W  packed operand B; 0 for unary ops.
- ALU_Sel  out  4  opcode.
- out_valid  out  1  transaction valid; held until out_ack.
- out_ack  in  1  downstream accepts the transaction.

Behaviour:
- Reset (rst_n low, asynchronous): state A_HI; A, B, ALU_Sel, internal digit registers = 0; out_valid, busy, err = 0.
- States and transitions:
  - A_HI: accepts a digit into a_hi, then goes to A_LO.
  - A_LO: accepts a digit into a_lo, then goes to OP.
  - OP: accepts an opcode. Binary ops (0000, 0001, 0100) go to B_HI. Unary ops (0010, 0011) go to ISSUE with B = 0.
  - B_HI: accepts a digit, then goes to B_LO.
  - B_LO: accepts a digit, then goes to ISSUE.
  - ISSUE: stays until out_ack, then returns to A_HI.
- Digit acceptance: digit_valid=1 and digit_in < BASE, in a digit state. The state advances on the same clock edge.
- Opcode acceptance: op_valid=1 and op_in ≤ MAX_OP, in OP.
- Packing is registered on entry to ISSUE: A = a_hi*10 + a_lo; B = b_hi*10 + b_lo. Computed at full OUT_W width; there is no overflow because max = 33.
- Latency: out_valid rises on the edge that accepts the final digit (or the unary opcode), so it is visible the following cycle. A, B and ALU_Sel are stable whenever out_valid=1.
- Handshake: out_ack sampled high while out_valid=1 causes out_valid=0 next cycle and the state to return to A_HI. out_ack while out_valid=0 is ignored.
- Error cases (err pulses one cycle; state and registers unchanged):
  - digit_in ≥ BASE in a digit state;
  - op_in > MAX_OP in OP;
  - op_valid in a digit state;
  - digit_valid in OP.
- Simultaneous digit_valid and op_valid: the strobe matching the current state is processed and the other is ignored without err. If neither matches, a single err pulse is raised.
- ISSUE: all entry strobes are ignored, with no err. busy=1.
- clear: highest priority after reset.
  - State returns to A_HI, internal digits = 0, out_valid=0 next cycle, err=0.
  - A, B and ALU_Sel keep their last values; they are don't-care when out_valid=0.
  - clear together with out_ack behaves as clear.
- Reset mid-transaction: immediate return to reset values; no partial transaction is emitted.

Decomposition:
- Shared package q_alu_pkg:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_SHL=2, OP_SHR=3, OP_GT=4;
  - Q_BASE=4, Q_PACK_W=7;
  - state enum {A_HI, A_LO, OP, B_HI, B_LO, ISSUE};
  - function is_unary(op).
- One natural sub-module, q_digit_pack: combinational (hi, lo) → packed value plus legal flag. Instantiated twice, for A and B.

Test Plan:
- Add: digits 1,2 / op 0000 / digits 3,1 → out_valid next cycle with A=12, B=31, ALU_Sel=0000. Hold out_ack=0 for 5 cycles → outputs stable. Pulse out_ack → out_valid=0, state A_HI.
- Unary: digits 2,3 / op 0011 → out_valid with A=23, B=0, ALU_Sel=0011. No B digits are requested.
- Illegal inputs: digit 5 in A_HI → err 1 cycle, still A_HI. Later, op 0111 in OP → err, still OP. Then op 0001 → accepted.
- Wrong kind and simultaneous: op_valid in A_LO → err. digit_valid and op_valid together in B_HI with digit 2 → digit accepted, no err.
- Busy: during ISSUE, digit_valid pulses → ignored, no err, busy=1, A/B unchanged.
- Abort: clear after 3 accepted inputs → A_HI, out_valid=0. Assert rst_n=0 asynchronously mid-B entry → all outputs 0 immediately. Full re-entry 3,3 / 0100 / 0,0 → A=33, B=0, ALU_Sel=0100.

Source files
------------

// File: rtl/q_alu_pkg.sv
// Shared definitions for the quaternary ALU operand-entry path:
// opcode encodings, digit radix, packed operand width and entry states.
package q_alu_pkg;

  localparam int Q_BASE   = 4;
  localparam int Q_PACK_W = 7;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SHL = 4'd2;
  localparam logic [3:0] OP_SHR = 4'd3;
  localparam logic [3:0] OP_GT  = 4'd4;

  typedef enum logic [2:0] {
    A_HI,
    A_LO,
    OP,
    B_HI,
    B_LO,
    ISSUE
  } entry_state_e;

  // Shifts take a single operand; everything else needs B as well.
  function automatic logic is_unary(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/q_digit_pack.sv
// Combinational packer: two base-BASE digits into tens*10 + ones,
// with a flag that both digits are within the radix.
module q_digit_pack
  import q_alu_pkg::*;
#(
  parameter int BASE  = Q_BASE,
  parameter int OUT_W = Q_PACK_W
) (
  input  logic [3:0]       i_hi,
  input  logic [3:0]       i_lo,
  output logic [OUT_W-1:0] o_packed,
  output logic             o_legal
);

  localparam logic [3:0]       LP_BASE = 4'(BASE);
  localparam logic [OUT_W-1:0] LP_TEN  = OUT_W'(10);

  logic [OUT_W-1:0] w_hi_ext;
  logic [OUT_W-1:0] w_lo_ext;

  assign w_hi_ext = OUT_W'(i_hi);
  assign w_lo_ext = OUT_W'(i_lo);
  assign o_packed = (w_hi_ext * LP_TEN) + w_lo_ext;
  assign o_legal  = (i_hi < LP_BASE) && (i_lo < LP_BASE);

endmodule

// File: rtl/q_operand_entry.sv
// Operand-entry stage: collects A digits, opcode and (for binary ops) B
// digits, then holds one packed transaction under a valid/ack handshake.
module q_operand_entry
  import q_alu_pkg::*;
#(
  parameter int BASE   = Q_BASE,
  parameter int MAX_OP = 4,
  parameter int OUT_W  = Q_PACK_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [3:0]       digit_in,
  input  logic             digit_valid,
  input  logic [3:0]       op_in,
  input  logic             op_valid,
  output logic             busy,
  output logic             err,
  output logic [OUT_W-1:0] A,
  output logic [OUT_W-1:0] B,
  output logic [3:0]       ALU_Sel,
  output logic             out_valid,
  input  logic             out_ack
);

  localparam logic [3:0] LP_BASE   = 4'(BASE);
  localparam logic [3:0] LP_MAX_OP = 4'(MAX_OP);

  entry_state_e r_state;
  entry_state_e w_state_nxt;

  logic [3:0]       r_a_hi, r_a_lo, r_b_hi, r_b_lo;
  logic [3:0]       r_op;
  logic             r_err;
  logic [OUT_W-1:0] r_a, r_b;
  logic [3:0]       r_alu_sel;

  logic             w_digit_state;
  logic             w_digit_ok;
  logic             w_op_ok;
  logic             w_accept_digit;
  logic             w_accept_op;
  logic             w_reject;
  logic             w_issue_load;
  logic             w_issue_unary;
  logic [3:0]       w_issue_op;
  logic [3:0]       w_b_lo_src;
  logic [OUT_W-1:0] w_a_packed, w_b_packed;
  logic             w_a_legal, w_b_legal;

  assign w_digit_state = (r_state == A_HI) || (r_state == A_LO) ||
                         (r_state == B_HI) || (r_state == B_LO);
  assign w_digit_ok    = digit_valid && (digit_in < LP_BASE);
  assign w_op_ok       = op_valid && (op_in <= LP_MAX_OP);

  // B_LO's digit is packed on the same edge that captures it, so bypass it.
  assign w_b_lo_src = (r_state == B_LO) ? digit_in : r_b_lo;

  q_digit_pack #(.BASE(BASE), .OUT_W(OUT_W)) u_pack_a (
    .i_hi     (r_a_hi),
    .i_lo     (r_a_lo),
    .o_packed (w_a_packed),
    .o_legal  (w_a_legal)
  );

  q_digit_pack #(.BASE(BASE), .OUT_W(OUT_W)) u_pack_b (
    .i_hi     (r_b_hi),
    .i_lo     (w_b_lo_src),
    .o_packed (w_b_packed),
    .o_legal  (w_b_legal)
  );

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_accept_digit = 1'b0;
    w_accept_op    = 1'b0;
    w_reject       = 1'b0;
    w_issue_load   = 1'b0;
    w_issue_unary  = 1'b0;
    w_issue_op     = r_op;

    if (w_digit_state) begin
      if (digit_valid) begin
        if (w_digit_ok) w_accept_digit = 1'b1;
        else            w_reject       = 1'b1;
      end else if (op_valid) begin
        w_reject = 1'b1;
      end
    end else if (r_state == OP) begin
      if (op_valid) begin
        if (w_op_ok) w_accept_op = 1'b1;
        else         w_reject    = 1'b1;
      end else if (digit_valid) begin
        w_reject = 1'b1;
      end
    end

    unique case (r_state)
      A_HI: if (w_accept_digit) w_state_nxt = A_LO;
      A_LO: if (w_accept_digit) w_state_nxt = OP;
      OP: begin
        if (w_accept_op) begin
          w_issue_op = op_in;
          if (is_unary(op_in)) begin
            w_issue_unary = 1'b1;
            w_issue_load  = w_a_legal;
            w_state_nxt   = ISSUE;
          end else begin
            w_state_nxt = B_HI;
          end
        end
      end
      B_HI: if (w_accept_digit) w_state_nxt = B_LO;
      B_LO: begin
        if (w_accept_digit) begin
          w_issue_load = w_a_legal && w_b_legal;
          w_state_nxt  = ISSUE;
        end
      end
      ISSUE: if (out_ack) w_state_nxt = A_HI;
      default: w_state_nxt = A_HI;
    endcase
  end

  // NOTE: state and data registers use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= A_HI;
      r_a_hi    <= '0;
      r_a_lo    <= '0;
      r_b_hi    <= '0;
      r_b_lo    <= '0;
      r_op      <= '0;
      r_err     <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_alu_sel <= '0;
    end else if (clear) begin
      // Abort keeps the last presented A/B/ALU_Sel; only entry state is wiped.
      r_state <= A_HI;
      r_a_hi  <= '0;
      r_a_lo  <= '0;
      r_b_hi  <= '0;
      r_b_lo  <= '0;
      r_op    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_reject;
      if (w_accept_digit) begin
        unique case (r_state)
          A_HI:    r_a_hi <= digit_in;
          A_LO:    r_a_lo <= digit_in;
          B_HI:    r_b_hi <= digit_in;
          B_LO:    r_b_lo <= digit_in;
          default: ;
        endcase
      end
      if (w_accept_op) r_op <= op_in;
      if (w_issue_load) begin
        r_a       <= w_a_packed;
        r_b       <= w_issue_unary ? '0 : w_b_packed;
        r_alu_sel <= w_issue_op;
      end
    end
  end

  assign busy      = (r_state == ISSUE);
  assign out_valid = (r_state == ISSUE);
  assign err       = r_err;
  assign A         = r_a;
  assign B         = r_b;
  assign ALU_Sel   = r_alu_sel;

endmodule

// File: tb/tb_q_operand_entry.sv
// Directed bench for q_operand_entry: add, unary, illegal strobes, busy,
// clear and asynchronous reset, checked with immediate assertions.
module tb_q_operand_entry;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic [3:0] op_in;
  logic       op_valid;
  logic       busy;
  logic       err;
  logic [6:0] A;
  logic [6:0] B;
  logic [3:0] ALU_Sel;
  logic       out_valid;
  logic       out_ack;

  int checks = 0;
  int errors = 0;

  q_operand_entry dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .op_in       (op_in),
    .op_valid    (op_valid),
    .busy        (busy),
    .err         (err),
    .A           (A),
    .B           (B),
    .ALU_Sel     (ALU_Sel),
    .out_valid   (out_valid),
    .out_ack     (out_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_digit(input logic [3:0] d);
    digit_in    = d;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic send_op(input logic [3:0] o);
    op_in    = o;
    op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic ack();
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; digit_in = '0; digit_valid = 1'b0;
    op_in = '0; op_valid = 1'b0; out_ack = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy",      32'(busy), 0);
    check("rst_err",       32'(err), 0);
    check("rst_A",         32'(A), 0);
    check("rst_B",         32'(B), 0);
    check("rst_ALU_Sel",   32'(ALU_Sel), 0);
    rst_n = 1'b1;
    tick();

    // ack with nothing valid is ignored
    ack();
    check("stray_ack_valid", 32'(out_valid), 0);

    // Add: 12 + 31
    send_digit(4'd1);
    check("add_d1_err", 32'(err), 0);
    send_digit(4'd2);
    send_op(4'd0);
    check("add_op_busy", 32'(busy), 0);
    send_digit(4'd3);
    check("add_b_hi_valid", 32'(out_valid), 0);
    send_digit(4'd1);
    check("add_valid", 32'(out_valid), 1);
    check("add_busy",  32'(busy), 1);
    check("add_A",     32'(A), 12);
    check("add_B",     32'(B), 31);
    check("add_sel",   32'(ALU_Sel), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", 32'(out_valid), 1);
      check("hold_A",     32'(A), 12);
      check("hold_B",     32'(B), 31);
      check("hold_sel",   32'(ALU_Sel), 0);
    end
    ack();
    check("add_ack_valid", 32'(out_valid), 0);
    check("add_ack_busy",  32'(busy), 0);

    // Unary shr: 23, B forced 0, no B digits requested
    send_digit(4'd2);
    send_digit(4'd3);
    send_op(4'd3);
    check("shr_valid", 32'(out_valid), 1);
    check("shr_A",     32'(A), 23);
    check("shr_B",     32'(B), 0);
    check("shr_sel",   32'(ALU_Sel), 3);
    ack();
    check("shr_ack_valid", 32'(out_valid), 0);

    // Illegal digit / opcode, wrong-kind and simultaneous strobes
    send_digit(4'd5);
    check("bad_digit_err", 32'(err), 1);
    tick();
    check("bad_digit_err_pulse", 32'(err), 0);
    send_digit(4'd1);
    check("a_hi_after_bad_err", 32'(err), 0);
    send_digit(4'd0);
    send_op(4'd7);
    check("bad_op_err", 32'(err), 1);
    send_op(4'd1);
    check("sub_op_err", 32'(err), 0);
    check("sub_op_valid", 32'(out_valid), 0);
    send_op(4'd1);
    check("op_in_b_hi_err", 32'(err), 1);
    digit_in = 4'd2; digit_valid = 1'b1; op_in = 4'd0; op_valid = 1'b1;
    tick();
    digit_valid = 1'b0; op_valid = 1'b0;
    check("simul_err", 32'(err), 0);
    check("simul_valid", 32'(out_valid), 0);
    send_digit(4'd2);
    check("sub_valid", 32'(out_valid), 1);
    check("sub_A",     32'(A), 10);
    check("sub_B",     32'(B), 22);
    check("sub_sel",   32'(ALU_Sel), 1);

    // Busy: strobes ignored without err
    send_digit(4'd3);
    check("busy_err",  32'(err), 0);
    check("busy_busy", 32'(busy), 1);
    send_op(4'd0);
    check("busy_op_err", 32'(err), 0);
    send_digit(4'd9);
    check("busy_bad_err", 32'(err), 0);
    check("busy_A",   32'(A), 10);
    check("busy_B",   32'(B), 22);
    check("busy_sel", 32'(ALU_Sel), 1);
    ack();
    check("sub_ack_valid", 32'(out_valid), 0);

    // Wrong kind in A_LO, then clear after three accepted inputs
    send_digit(4'd3);
    send_op(4'd0);
    check("op_in_a_lo_err", 32'(err), 1);
    send_digit(4'd0);
    send_op(4'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_valid", 32'(out_valid), 0);
    check("clear_err",   32'(err), 0);
    check("clear_A_kept", 32'(A), 10);
    send_digit(4'd1);
    send_digit(4'd1);
    send_op(4'd2);
    check("post_clear_valid", 32'(out_valid), 1);
    check("post_clear_A",     32'(A), 11);
    check("post_clear_B",     32'(B), 0);
    check("post_clear_sel",   32'(ALU_Sel), 2);
    // clear together with ack acts as clear
    out_ack = 1'b1; clear = 1'b1;
    tick();
    out_ack = 1'b0; clear = 1'b0;
    check("clear_ack_valid", 32'(out_valid), 0);

    // Asynchronous reset mid-B entry
    send_digit(4'd2);
    send_digit(4'd1);
    send_op(4'd0);
    send_digit(4'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_A",     32'(A), 0);
    check("async_rst_B",     32'(B), 0);
    check("async_rst_sel",   32'(ALU_Sel), 0);
    check("async_rst_valid", 32'(out_valid), 0);
    check("async_rst_busy",  32'(busy), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", 32'(out_valid), 0);

    // Full re-entry: 33 gt with B = 00
    send_digit(4'd3);
    send_digit(4'd3);
    send_op(4'd4);
    check("gt_op_valid", 32'(out_valid), 0);
    send_digit(4'd0);
    send_digit(4'd0);
    check("gt_valid", 32'(out_valid), 1);
    check("gt_A",     32'(A), 33);
    check("gt_B",     32'(B), 0);
    check("gt_sel",   32'(ALU_Sel), 4);
    ack();
    check("gt_ack_valid", 32'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
